envelope_gen: RTL and testbench

Per-track amplitude envelope (attack/decay/sustain/release) stage between the SPI packet receiver and each track's tone generator core. It consumes the raw 24-bit note packet ({tuneWord[15:0], volume[7:0]}) and detects note-on, note-off and retrigger events. It emits a shaped packet of the same format whose volume ramps instead of stepping. This removes clicks at note boundaries and holds the tuneWord through the release tail. One instance per track, inserted on each `notePackets[i]` lane in `top`.

---
 rtl/envelope_gen_pkg.sv | 23 ++
 rtl/envelope_gen_if.sv | 12 +
 rtl/envelope_gen_tick.sv | 24 ++
 rtl/envelope_gen.sv | 124 ++++++++++++
 tb/tb_envelope_gen.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/envelope_gen_pkg.sv
// Shared types for the per-track envelope stage: packet layout and envelope state encoding.
package envelope_gen_pkg;

  localparam int PACKET_SIZE = 24;

  typedef logic [PACKET_SIZE-1:0] packetType;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } envState_t;

  // 8x8 product, keep the upper byte: (peak * num) >> 8.
  function automatic logic [7:0] sus_level(input logic [7:0] peak, input logic [7:0] num);
    logic [15:0] prod;
    prod = {8'd0, peak} * {8'd0, num};
    return prod[15:8];
  endfunction

endpackage

// File: rtl/envelope_gen_if.sv
// Note-packet lane into and out of one envelope stage; the slave side is the envelope itself.
interface envelope_gen_if;
  import envelope_gen_pkg::*;

  packetType notePacketIn;
  packetType notePacketOut;
  envState_t envState;

  modport master (output notePacketIn, input notePacketOut, input envState);
  modport slave  (input notePacketIn, output notePacketOut, output envState);

endinterface

// File: rtl/envelope_gen_tick.sv
// Free-running prescaler: one-cycle tick every STEP_DIV clocks, first tick STEP_DIV cycles after reset.
// Kept separate so several tracks can share a single instance.
module env_tick #(
  parameter int STEP_DIV = 4096
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/envelope_gen.sv
// ADSR shaping of a raw note packet: detects note-on/off/volume events, ramps the volume byte.
// Latency 1 cycle from input or tick to output; no backpressure, input may change every cycle.
module envelope_gen
  import envelope_gen_pkg::*;
#(
  parameter int STEP_DIV     = 4096,
  parameter int ATTACK_STEP  = 8,
  parameter int DECAY_STEP   = 2,
  parameter int RELEASE_STEP = 4,
  parameter int SUSTAIN_NUM  = 192
) (
  input  logic           clk,
  input  logic           reset,
  envelope_gen_if.slave  bus
);

  envState_t   state_q, state_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  peak_q, peak_d;
  logic [15:0] tune_q, tune_d;
  packetType   out_q;
  envState_t   st_out_q;

  logic        tick;
  logic [15:0] t_in;
  logic [7:0]  v_in;
  logic        note_on, active;
  logic [7:0]  sus;
  logic [8:0]  lvl9, sus9, peak9;

  env_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign t_in    = bus.notePacketIn[23:8];
  assign v_in    = bus.notePacketIn[7:0];
  assign note_on = (t_in != 16'd0) && (v_in != 8'd0);
  assign active  = (state_q == ATTACK) || (state_q == DECAY) || (state_q == SUSTAIN);
  assign sus     = sus_level(peak_q, 8'(SUSTAIN_NUM));
  assign lvl9    = {1'b0, level_q};
  assign sus9    = {1'b0, sus};
  assign peak9   = {1'b0, peak_q};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    peak_d  = peak_q;
    tune_d  = tune_q;

    if (note_on && (state_q == IDLE || state_q == RELEASE || t_in != tune_q)) begin
      tune_d  = t_in;
      peak_d  = v_in;
      state_d = ATTACK;
    end else if (!note_on && active) begin
      state_d = RELEASE;
    end else if (note_on && active && v_in != peak_q) begin
      peak_d = v_in;
    end else if (tick) begin
      case (state_q)
        IDLE: level_d = 8'd0;
        ATTACK: begin
          if (level_q > peak_q) begin
            state_d = DECAY;
          end else if (lvl9 + 9'(ATTACK_STEP) >= peak9) begin
            level_d = peak_q;
            state_d = DECAY;
          end else begin
            level_d = level_q + 8'(ATTACK_STEP);
          end
        end
        DECAY: begin
          if (lvl9 <= sus9 + 9'(DECAY_STEP)) begin
            level_d = sus;
            state_d = SUSTAIN;
          end else begin
            level_d = level_q - 8'(DECAY_STEP);
          end
        end
        SUSTAIN: begin
          // Follows sus in both directions so later volume changes are tracked smoothly.
          if (level_q > sus) begin
            level_d = (lvl9 <= sus9 + 9'(DECAY_STEP)) ? sus : level_q - 8'(DECAY_STEP);
          end else if (level_q < sus) begin
            level_d = (lvl9 + 9'(DECAY_STEP) >= sus9) ? sus : level_q + 8'(DECAY_STEP);
          end
        end
        RELEASE: begin
          if (lvl9 <= 9'(RELEASE_STEP)) begin
            level_d = 8'd0;
            state_d = IDLE;
          end else begin
            level_d = level_q - 8'(RELEASE_STEP);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= 8'd0;
      peak_q   <= 8'd0;
      tune_q   <= 16'd0;
      out_q    <= '0;
      st_out_q <= IDLE;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      tune_q   <= tune_d;
      // tuneWord is only exposed while the track is audible, and drops together with level 0.
      out_q    <= {(state_d != IDLE) ? tune_d : 16'd0, level_d};
      st_out_q <= state_d;
    end
  end

  assign bus.notePacketOut = out_q;
  assign bus.envState      = st_out_q;

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen with STEP_DIV=4; expected levels are hand-derived per scenario.
module tb_envelope_gen;
  import envelope_gen_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;

  always #5 clk = ~clk;

  envelope_gen_if bus ();

  envelope_gen #(
    .STEP_DIV     (4),
    .ATTACK_STEP  (8),
    .DECAY_STEP   (2),
    .RELEASE_STEP (4),
    .SUSTAIN_NUM  (192)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] tune, input logic [7:0] lvl,
                         input envState_t st);
    check({tag, ".pkt"}, 32'(bus.notePacketOut), {8'h00, tune, lvl});
    check({tag, ".st"}, 32'(bus.envState), 32'(st));
  endtask

  // One clock edge; outputs are sampled on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    ecount++;
    @(negedge clk);
  endtask

  // Edge index k (counted from reset release) is a tick when k%4==3.
  task automatic next_tick();
    do cyc(); while (ecount % 4 != 0);
  endtask

  task automatic to_pre_tick();
    while (ecount % 4 != 3) cyc();
  endtask

  initial begin
    int e;
    reset = 1'b1;
    bus.notePacketIn = 24'h1234FF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("reset_hold", 16'h0, 8'h0, IDLE);
    end
    reset = 1'b0;
    bus.notePacketIn = 24'h0;
    ecount = 0;
    cyc();
    chk_out("post_reset", 16'h0, 8'h0, IDLE);

    // Note-on from IDLE, attack to 0xFF, decay to 191.
    bus.notePacketIn = 24'h1234FF;
    cyc();
    chk_out("note_on", 16'h1234, 8'h00, ATTACK);
    next_tick();
    chk_out("atk1", 16'h1234, 8'd8, ATTACK);
    cyc();
    chk_out("atk1_hold", 16'h1234, 8'd8, ATTACK);
    for (int t = 2; t <= 32; t++) begin
      next_tick();
      e = (t * 8 > 255) ? 255 : t * 8;
      chk_out("atk", 16'h1234, 8'(e), (t == 32) ? DECAY : ATTACK);
    end
    for (int t = 1; t <= 32; t++) begin
      next_tick();
      chk_out("decay", 16'h1234, 8'(255 - 2 * t), (t == 32) ? SUSTAIN : DECAY);
    end

    // Note-off at 191: 48 release ticks to silence.
    bus.notePacketIn = 24'h123400;
    cyc();
    chk_out("note_off", 16'h1234, 8'd191, RELEASE);
    for (int t = 1; t <= 48; t++) begin
      next_tick();
      if (t < 48) chk_out("release", 16'h1234, 8'(191 - 4 * t), RELEASE);
      else        chk_out("release_end", 16'h0, 8'h0, IDLE);
    end

    // Back up to sustain 191.
    bus.notePacketIn = 24'h1234FF;
    cyc();
    chk_out("note_on2", 16'h1234, 8'h00, ATTACK);
    repeat (64) next_tick();
    chk_out("resustain", 16'h1234, 8'd191, SUSTAIN);

    // Volume drop in SUSTAIN: sus becomes 48; a second change lands on a tick.
    bus.notePacketIn = 24'h123440;
    cyc();
    chk_out("vol_chg", 16'h1234, 8'd191, SUSTAIN);
    for (int t = 1; t <= 20; t++) begin
      next_tick();
      chk_out("sus_track", 16'h1234, 8'(191 - 2 * t), SUSTAIN);
    end
    to_pre_tick();
    bus.notePacketIn = 24'h123441;
    cyc();
    chk_out("vol_on_tick", 16'h1234, 8'd151, SUSTAIN);
    for (int t = 21; t <= 73; t++) begin
      next_tick();
      e = 191 - 2 * t;
      if (e < 48) e = 48;
      chk_out("sus_track2", 16'h1234, 8'(e), SUSTAIN);
    end

    // Release from 48, then retrigger a new tune at level 40.
    bus.notePacketIn = 24'h123400;
    cyc();
    chk_out("off2", 16'h1234, 8'd48, RELEASE);
    next_tick();
    chk_out("rel2a", 16'h1234, 8'd44, RELEASE);
    next_tick();
    chk_out("rel2b", 16'h1234, 8'd40, RELEASE);
    bus.notePacketIn = 24'h080080;
    cyc();
    chk_out("retrig", 16'h0800, 8'd40, ATTACK);
    for (int t = 1; t <= 11; t++) begin
      next_tick();
      chk_out("retrig_atk", 16'h0800, 8'(40 + 8 * t), (t == 11) ? DECAY : ATTACK);
    end
    next_tick();
    chk_out("retrig_decay", 16'h0800, 8'd126, DECAY);

    // New tune with peak below the current level: straight to DECAY, no step.
    bus.notePacketIn = 24'h090010;
    cyc();
    chk_out("low_peak_on", 16'h0900, 8'd126, ATTACK);
    next_tick();
    chk_out("low_peak_skip", 16'h0900, 8'd126, DECAY);
    next_tick();
    chk_out("low_peak_decay", 16'h0900, 8'd124, DECAY);

    // Reset mid-operation.
    reset = 1'b1;
    cyc();
    chk_out("mid_reset", 16'h0, 8'h0, IDLE);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
